reverse_bits_arbiter: RTL and testbench
=======================================

// Module: reverse_bits_arbiter
// PURPOSE
//  Shares one bit-reversal datapath between two requesters, A and B.
//  Each requester has a valid/ready input handshake; a round-robin arbiter picks
//  one request per cycle. A single registered output stage carries the result and
//  a source tag, with valid/ready backpressure. Per-requester served counters
//  support debug and verification. Sits between the stimulus sources and the consumer.
// PARAMETERS
//  WIDTH  8  data width of requests and results
//  CNT_W  8  width of the served_a / served_b counters (wrap modulo 2^CNT_W)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  a_valid   in   1      requester A presents a_data
//  a_data    in   WIDTH  requester A operand
//  a_ready   out  1      A transfer occurs when a_valid & a_ready at posedge
//  b_valid   in   1      requester B presents b_data
//  b_data    in   WIDTH  requester B operand
//  b_ready   out  1      B transfer occurs when b_valid & b_ready at posedge
//  out_valid out  1      out_data/out_src hold a result
//  out_data  out  WIDTH  bit-reversed operand: out_data[WIDTH-1-i] = in[i]
//  out_src   out  1      0 = result from A, 1 = result from B
//  out_ready in   1      consumer accepts when out_valid & out_ready at posedge
//  served_a  out  CNT_W  count of accepted A transfers
//  served_b  out  CNT_W  count of accepted B transfers
// BEHAVIOUR
//  - Reset (async on rst_n low): out_valid=0, out_data=0, out_src=0, served_a=0,
//    served_b=0, last_src=1 (A wins the first tie). While rst_n=0, a_ready=b_ready=0.
//  - FSM (state is out_valid):
//    - EMPTY -> FULL on any input transfer.
//    - FULL -> EMPTY on drain with no new transfer.
//    - FULL -> FULL on drain plus a same-cycle transfer, or on stall.
//  - can_accept = !out_valid | out_ready (combinational).
//  - Grant (combinational):
//    - grant_a = a_valid & (!b_valid | last_src==1).
//    - grant_b = b_valid & (!a_valid | last_src==0).
//    - Grants are mutually exclusive.
//  - a_ready = can_accept & grant_a; b_ready = can_accept & grant_b.
//    - Ready depends on the other requester's valid.
//    - No path from ready to the same requester's valid.
//  - On a transfer at edge N:
//    - out_data = reversed operand; out_src = winner; out_valid=1 after edge N (latency 1).
//    - last_src = winner; the winner's served counter increments, wrapping to 0.
//  - Throughput: 1 result/cycle while out_ready=1. Both valid -> strict A/B alternation.
//  - Stall (out_valid=1, out_ready=0):
//    - out_data/out_src held stable; a_ready=b_ready=0.
//    - Pending requesters wait; last_src unchanged.
//  - A requester may drop valid before being granted; no state is kept for it.
//  - Reset mid-operation: the held result is discarded (out_valid=0 immediately);
//    counters clear; arbitration restarts with A priority.
// TESTING
//  1 rst_n=0 with a_valid=b_valid=1 -> a_ready=b_ready=0, out_valid=0, served_*=0
//  2 a_data=8'b0000_0001, a_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1,
//    out_data=8'b1000_0000, out_src=0, served_a=1
//  3 a=8'h0F, b=8'h33 both held valid, out_ready=1 -> outputs 8'hF0/src0, 8'hCC/src1,
//    8'hF0/src0, ... alternating; after 6 cycles served_a=3, served_b=3
//  4 out_valid=1, out_ready=0 for 3 cycles -> out_data stable, both ready=0;
//    raise out_ready with b_valid=1 -> B accepted that same edge, no bubble
//  5 CNT_W=4, 17 A-only transfers -> served_a=1, served_b=0
//  6 rst_n pulsed low while out_valid=1 -> out_valid=0 asynchronously; after release
//    both valid -> A granted first

Source files
------------

// File: rtl/reverse_bits_arbiter.sv
// reverse_bits_arbiter
//   Two requesters (A, B) share one bit-reversal datapath. A round-robin
//   arbiter grants at most one request per cycle; the winner's operand is
//   bit-reversed into a single registered output stage tagged with its source.
//   The output stage uses valid/ready backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a_valid    requester A presents a_data
//   a_data     requester A operand
//   a_ready    A transfers when a_valid & a_ready at posedge
//   b_valid    requester B presents b_data
//   b_data     requester B operand
//   b_ready    B transfers when b_valid & b_ready at posedge
//   out_valid  out_data / out_src hold a result
//   out_data   bit-reversed operand (out_data[WIDTH-1-i] = in[i])
//   out_src    0 = result from A, 1 = result from B
//   out_ready  consumer accepts when out_valid & out_ready at posedge
//   served_a   accepted A transfers, wraps modulo 2^CNT_W
//   served_b   accepted B transfers, wraps modulo 2^CNT_W
module reverse_bits_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] served_a,
    output logic [CNT_W-1:0] served_b
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_src_q, out_src_d;
    logic               last_src_q, last_src_d;
    logic [CNT_W-1:0]   served_a_q, served_a_d;
    logic [CNT_W-1:0]   served_b_q, served_b_d;

    logic               can_accept;
    logic               grant_a;
    logic               grant_b;
    logic               xfer_a;
    logic               xfer_b;
    logic               xfer;
    logic [WIDTH-1:0]   rev_a;
    logic [WIDTH-1:0]   rev_b;

    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            rev_a[WIDTH-1-i] = a_data[i];
            rev_b[WIDTH-1-i] = b_data[i];
        end
    end

    // last_src == 1 means B won last, so A has priority on a tie.
    always_comb begin
        grant_a    = a_valid & (~b_valid | last_src_q);
        grant_b    = b_valid & (~a_valid | ~last_src_q);
        can_accept = (state_q == StEmpty) | out_ready;
        // Readies are forced low while reset is asserted.
        a_ready    = rst_n & can_accept & grant_a;
        b_ready    = rst_n & can_accept & grant_b;
        xfer_a     = a_valid & a_ready;
        xfer_b     = b_valid & b_ready;
        xfer       = xfer_a | xfer_b;
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        last_src_d = last_src_q;
        served_a_d = served_a_q;
        served_b_d = served_b_q;

        unique case (state_q)
            StEmpty: begin
                if (xfer) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (xfer) begin
                    state_d = StFull;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (xfer_a) begin
            out_data_d = rev_a;
            out_src_d  = 1'b0;
            last_src_d = 1'b0;
            served_a_d = served_a_q + CNT_W'(1);
        end else if (xfer_b) begin
            out_data_d = rev_b;
            out_src_d  = 1'b1;
            last_src_d = 1'b1;
            served_b_d = served_b_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            last_src_q <= 1'b1;
            served_a_q <= '0;
            served_b_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            last_src_q <= last_src_d;
            served_a_q <= served_a_d;
            served_b_q <= served_b_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign served_a  = served_a_q;
    assign served_b  = served_b_q;

endmodule

// File: tb/tb_reverse_bits_arbiter.sv
// Testbench for reverse_bits_arbiter: a WIDTH=8/CNT_W=8 instance and a
// CNT_W=4 instance share all inputs. A small reference model predicts grants
// and output-stage occupancy; expected results go into a scoreboard queue when
// a transfer is predicted and are compared while the output holds them.
module tb_reverse_bits_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, out_valid, out_src;
    logic [7:0] out_data, served_a, served_b;
    logic       a_ready2, b_ready2, out_valid2, out_src2;
    logic [7:0] out_data2;
    logic [3:0] served_a2, served_b2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic       m_valid;
    logic       m_last;
    int         m_sa, m_sb;
    logic [8:0] sb_q[$];   // {src, data}

    reverse_bits_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .served_a(served_a), .served_b(served_b)
    );

    reverse_bits_arbiter #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_src(out_src2),
        .out_ready(out_ready), .served_a(served_a2), .served_b(served_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 1'b1;
        m_sa    = 0;
        m_sb    = 0;
        sb_q.delete();
    endtask

    // Check DUT against model at negedge, advance model, return at posedge+1.
    task automatic cycle(input string tag);
        logic can, ga, gb, xa, xb;
        @(negedge clk);
        can = ~m_valid | out_ready;
        ga  = a_valid & (~b_valid | m_last);
        gb  = b_valid & (~a_valid | ~m_last);
        xa  = can & ga;
        xb  = can & gb;
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(xa));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(xb));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid && sb_q.size() > 0) begin
            chk({tag, ".out_data"}, 32'(out_data), 32'(sb_q[0][7:0]));
            chk({tag, ".out_src"}, 32'(out_src), 32'(sb_q[0][8]));
        end
        chk({tag, ".served_a"}, 32'(served_a), 32'(m_sa % 256));
        chk({tag, ".served_b"}, 32'(served_b), 32'(m_sb % 256));
        chk({tag, ".served_a4"}, 32'(served_a2), 32'(m_sa % 16));
        if (m_valid && out_ready) void'(sb_q.pop_front());
        if (xa) begin
            sb_q.push_back({1'b0, rev8(a_data)});
            m_last = 1'b0;
            m_sa++;
        end else if (xb) begin
            sb_q.push_back({1'b1, rev8(b_data)});
            m_last = 1'b1;
            m_sb++;
        end
        m_valid = xa | xb | (m_valid & ~out_ready);
        @(posedge clk);
        #1;
    endtask

    // Test 1 conditions: reset held with both requesters valid.
    task automatic do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("rst.a_ready", 32'(a_ready), 32'd0);
        chk("rst.b_ready", 32'(b_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.served_a", 32'(served_a), 32'd0);
        chk("rst.served_b", 32'(served_b), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold.a_ready", 32'(a_ready), 32'd0);
        chk("rst_hold.out_data", 32'(out_data), 32'd0);
        model_reset();
        rst_n   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_data    = '0;
        b_data    = '0;
        out_ready = 1'b1;
        model_reset();
        #2;

        // 1: reset behaviour
        do_reset();

        // 2: single A transfer, latency 1
        a_data  = 8'b0000_0001;
        a_valid = 1'b1;
        cycle("t2.xfer");
        a_valid = 1'b0;
        chk("t2.out_data", 32'(out_data), 32'h80);
        chk("t2.out_src", 32'(out_src), 32'd0);
        chk("t2.served_a", 32'(served_a), 32'd1);
        cycle("t2.drain");
        cycle("t2.idle");

        // 3: both valid, strict alternation starting with A
        do_reset();
        a_data  = 8'h0F;
        b_data  = 8'h33;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle("t3.alt");
            chk("t3.src_alt", 32'(out_src), 32'(i % 2));
            chk("t3.data_alt", 32'(out_data), (i % 2 == 0) ? 32'hF0 : 32'hCC);
        end
        chk("t3.served_a", 32'(served_a), 32'd3);
        chk("t3.served_b", 32'(served_b), 32'd3);
        a_valid = 1'b0;
        b_valid = 1'b0;
        cycle("t3.drain");

        // 4: stall for 3 cycles, then release with B pending
        do_reset();
        a_data  = 8'b1010_0011;
        a_valid = 1'b1;
        cycle("t4.load");
        a_valid   = 1'b0;
        b_data    = 8'b0001_0110;
        b_valid   = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("t4.stall");
            chk("t4.held", 32'(out_data), 32'hC5);
        end
        out_ready = 1'b1;
        cycle("t4.release");
        chk("t4.b_data", 32'(out_data), 32'h68);
        chk("t4.b_src", 32'(out_src), 32'd1);
        b_valid = 1'b0;
        cycle("t4.drain");

        // 5: 17 A-only transfers, CNT_W=4 instance wraps to 1
        do_reset();
        a_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_data = 8'(i * 37 + 5);
            cycle("t5.xfer");
        end
        a_valid = 1'b0;
        chk("t5.served_a4", 32'(served_a2), 32'd1);
        chk("t5.served_b4", 32'(served_b2), 32'd0);
        chk("t5.served_a8", 32'(served_a), 32'd17);
        cycle("t5.drain");

        // 6: asynchronous reset with a held result
        do_reset();
        b_data    = 8'h81;
        b_valid   = 1'b1;
        out_ready = 1'b0;
        cycle("t6.load");
        chk("t6.loaded", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.async_clear", 32'(out_valid), 32'd0);
        chk("t6.served_b_clear", 32'(served_b), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        a_data    = 8'h3C;
        a_valid   = 1'b1;
        b_data    = 8'h55;
        b_valid   = 1'b1;
        #1;
        chk("t6.a_first", 32'(a_ready), 32'd1);
        chk("t6.b_wait", 32'(b_ready), 32'd0);
        cycle("t6.first");
        chk("t6.first_src", 32'(out_src), 32'd0);
        cycle("t6.second");
        chk("t6.second_src", 32'(out_src), 32'd1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        cycle("t6.drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
